step_control: RTL and testbench
===============================

Name: step_control

Overview:
- Control section directly downstream of the clock generator and six-step stepper.
- Consumes the one-hot step vector and the enable/set clock phases (clke, clks).
- Decodes the fetch cycle and the current instruction into bus-enable and register-set strobes.
- Holds the instruction register, the flags register, a retired-instruction counter and a sticky step-fault flag.

Parameters:
- WIDTH, 8: bus and IR width.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  system clock, same clock that drives the clock generator.
- reset  in  1  asynchronous, active-low reset.
- clke  in  1  enable phase from the clock generator.
- clks  in  1  set phase from the clock generator.
- step  in  6  stepper one-hot; bit0 = step 1 … bit5 = step 6.
- bus  in  WIDTH  data bus, sampled for IR load.
- alu_c, alu_a, alu_e, alu_z  in  1 each  ALU carry, a-larger, equal and zero outputs.
- bus1  out  1  forces bus value 1 into the ALU B input.
- e_ram, e_acc, e_iar  out  1 each  bus enables.
- e_reg  out  4  one-hot general-register enable.
- s_mar, s_ir, s_iar, s_acc, s_ram, s_tmp, s_flags  out  1 each  register sets.
- s_reg  out  4  one-hot general-register set.
- alu_op  out  3  ALU opcode; 000 = ADD.
- alu_cin  out  1  ALU carry-in.
- ir  out  WIDTH  instruction register.
- flags  out  4  {C,A,E,Z}.
- icount  out  CNT_W  instructions retired.
- err  out  1  sticky step fault.

Behaviour:
- Reset values: all strobes, ir, flags, icount and err are 0, alu_op = 000.
- Output gating:
  - Every e_* and bus1 output = clke AND (decoded step term).
  - Every s_* output = clks AND (decoded step term).
  - alu_op and alu_cin are clke-independent but valid only in their step.
- Field decode: RA = ir[3:2], RB = ir[1:0]; e_reg/s_reg index RA or RB as listed.
- Fetch cycle:
  - step 1: bus1, e_iar, s_mar, s_acc (ADD).
  - step 2: e_ram, s_ir.
  - step 3: e_acc, s_iar.
- Steps 4-6 by ir[7:4]:
  - 1xxx ALU: s4 e_reg[RB], s_tmp; s5 e_reg[RA], s_acc, s_flags, alu_op = ir[6:4], alu_cin = flags.C; s6 e_acc, s_reg[RB] except when op = 111 (CMP).
  - 0000 LD: s4 e_reg[RA], s_mar; s5 e_ram, s_reg[RB].
  - 0001 ST: s4 e_reg[RA], s_mar; s5 e_reg[RB], s_ram.
  - 0010 DATA: s4 bus1, e_iar, s_mar, s_acc; s5 e_ram, s_reg[RB]; s6 e_acc, s_iar.
  - 0011 JMPR: s4 e_reg[RB], s_iar.
  - 0100 JMP: s4 e_iar, s_mar; s5 e_ram, s_iar.
  - 0101 JCAEZ: s4 bus1, e_iar, s_mar, s_acc; s5 e_acc, s_iar; s6 e_ram, s_iar only if (ir[3:0] & flags) != 0.
  - 0110 CLF: s4 bus1, s_flags; flags load 0000 regardless of ALU inputs.
  - 0111: no strobes (NOP).
- IR register: on posedge clk, loads bus when the internal s_ir term and clks are both high. The value is held until the next load.
- Flags register: on posedge clk, loads {alu_c,alu_a,alu_e,alu_z} (or 0000 for CLF) when the s_flags term and clks are both high.
- Retired-instruction counter:
  - Increments by 1, modulo 2^CNT_W (wraps to 0), on each posedge where the previous sample of step had bit5 set and the current sample has bit0 set.
  - Multi-cycle step dwell counts once only.
- Step faults:
  - step == 0 is idle: all strobes low, no fault.
  - More than one bit set: all strobes forced low the same cycle, and err sets on the next posedge.
  - err stays set until reset.
- Simultaneous clke and clks: both strobe groups are driven. This is legal because the phases overlap by design.
- Reset mid-instruction: all outputs and registers return to reset values asynchronously.
- First post-reset fetch is unaffected.

Decomposition:
- Shared package holds:
  - opcode constants (OP_ALU, OP_LD, OP_ST, OP_DATA, OP_JMPR, OP_JMP, OP_JCOND, OP_CLF);
  - ALU op constants (ADD … CMP = 3'b111);
  - flag bit positions.
- One sub-module is natural: step_decode, purely combinational (step, ir, flags → ungated strobe terms).
- The top level handles phase gating and all registers.

Test Plan:
- Fetch, ADD:
  - Stimulus: reset, then steps 1-3 with bus = 8'h81 at step 2 clks.
  - Response: ir = 8'h81; step 1 clke gives bus1 = e_iar = 1; step 3 clks gives s_iar = 1.
- ALU ADD R0,R1 (ir 8'h81):
  - s4: e_reg = 0010, s_tmp.
  - s5: e_reg = 0001, alu_op = 000, s_flags. With alu_c = 1, flags = 4'b1000 after clks.
  - s6: s_reg = 0010.
- Conditional jump:
  - JC with C = 1 (ir 8'h58): s6 gives e_ram, s_iar.
  - JC with flags = 0: no s6 strobes.
- CMP and CLF:
  - CMP (ir 8'hF1): no s_reg at s6.
  - Then CLF (8'h60): flags = 0000 even with all alu_* = 1.
- Step fault and counting:
  - step = 6'b000011: all strobes 0, and err = 1 next cycle, held until reset.
  - Three full 6-step cycles: icount = 3.
- Async reset:
  - Assert reset at step 5 of the ALU sequence: all outputs 0 immediately, and icount = 0.

Source files
------------

// File: rtl/step_control_pkg.sv
// Shared opcode, ALU-op and flag definitions for the step_control block and its decoder.
// The strobe bundle struct carries ungated decode terms from step_decode to the top level.
package step_control_pkg;

  localparam logic [3:0] OP_ALU   = 4'b1000;  // only bit 3 is significant
  localparam logic [3:0] OP_LD    = 4'b0000;
  localparam logic [3:0] OP_ST    = 4'b0001;
  localparam logic [3:0] OP_DATA  = 4'b0010;
  localparam logic [3:0] OP_JMPR  = 4'b0011;
  localparam logic [3:0] OP_JMP   = 4'b0100;
  localparam logic [3:0] OP_JCOND = 4'b0101;
  localparam logic [3:0] OP_CLF   = 4'b0110;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SHR = 3'b001,
    ALU_SHL = 3'b010,
    ALU_NOT = 3'b011,
    ALU_AND = 3'b100,
    ALU_OR  = 3'b101,
    ALU_XOR = 3'b110,
    ALU_CMP = 3'b111
  } alu_op_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_A = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_Z = 0;

  typedef struct packed {
    logic       bus1;
    logic       e_ram;
    logic       e_acc;
    logic       e_iar;
    logic [3:0] e_reg;
    logic       s_mar;
    logic       s_ir;
    logic       s_iar;
    logic       s_acc;
    logic       s_ram;
    logic       s_tmp;
    logic       s_flags;
    logic [3:0] s_reg;
    alu_op_e    alu_op;
    logic       alu_cin;
    logic       flags_clr;
  } strobes_t;

  // True when more than one stepper bit is set.
  function automatic logic multi_hot(input logic [5:0] v);
    return (v & (v - 6'd1)) != 6'd0;
  endfunction

  function automatic logic [3:0] reg_sel(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/step_control_if.sv
// Bundle of clock phases, stepper, bus/ALU inputs and all decoded strobes around step_control.
// master = upstream clock generator / datapath side, slave = step_control.
interface step_control_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             clke;
    logic             clks;
    logic [5:0]       step;
    logic [WIDTH-1:0] bus;
    logic             alu_c;
    logic             alu_a;
    logic             alu_e;
    logic             alu_z;

    logic             bus1;
    logic             e_ram;
    logic             e_acc;
    logic             e_iar;
    logic [3:0]       e_reg;
    logic             s_mar;
    logic             s_ir;
    logic             s_iar;
    logic             s_acc;
    logic             s_ram;
    logic             s_tmp;
    logic             s_flags;
    logic [3:0]       s_reg;
    logic [2:0]       alu_op;
    logic             alu_cin;
    logic [WIDTH-1:0] ir;
    logic [3:0]       flags;
    logic [CNT_W-1:0] icount;
    logic             err;

    modport master (
        output clke, clks, step, bus, alu_c, alu_a, alu_e, alu_z,
        input  bus1, e_ram, e_acc, e_iar, e_reg,
        input  s_mar, s_ir, s_iar, s_acc, s_ram, s_tmp, s_flags, s_reg,
        input  alu_op, alu_cin, ir, flags, icount, err
    );

    modport slave (
        input  clke, clks, step, bus, alu_c, alu_a, alu_e, alu_z,
        output bus1, e_ram, e_acc, e_iar, e_reg,
        output s_mar, s_ir, s_iar, s_acc, s_ram, s_tmp, s_flags, s_reg,
        output alu_op, alu_cin, ir, flags, icount, err
    );
endinterface

// File: rtl/step_control_decode.sv
// Purely combinational decode of stepper position, IR and flags into ungated strobe terms.
// A zero or multi-hot step vector yields no terms at all.
module step_decode
    import step_control_pkg::*;
(
    input  logic [5:0] step,
    input  logic [7:0] ir,
    input  logic [3:0] flags,
    output strobes_t   terms
);

    logic [1:0] ra;
    logic [1:0] rb;
    logic [3:0] opc;
    logic       incr;

    assign ra  = ir[3:2];
    assign rb  = ir[1:0];
    assign opc = ir[7:4];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        terms = '0;
        incr  = 1'b0;
        if (!multi_hot(step)) begin
            if (step[0]) begin
                incr = 1'b1;
            end else if (step[1]) begin
                terms.e_ram = 1'b1;
                terms.s_ir  = 1'b1;
            end else if (step[2]) begin
                terms.e_acc = 1'b1;
                terms.s_iar = 1'b1;
            end else if (opc[3] == OP_ALU[3]) begin
                if (step[3]) begin
                    terms.e_reg = reg_sel(rb);
                    terms.s_tmp = 1'b1;
                end else if (step[4]) begin
                    terms.e_reg   = reg_sel(ra);
                    terms.s_acc   = 1'b1;
                    terms.s_flags = 1'b1;
                    terms.alu_op  = alu_op_e'(opc[2:0]);
                    terms.alu_cin = flags[FLAG_C];
                end else if (step[5] && alu_op_e'(opc[2:0]) != ALU_CMP) begin
                    terms.e_acc = 1'b1;
                    terms.s_reg = reg_sel(rb);
                end
            end else begin
                case (opc)
                    OP_LD, OP_ST: begin
                        if (step[3]) begin
                            terms.e_reg = reg_sel(ra);
                            terms.s_mar = 1'b1;
                        end else if (step[4] && opc == OP_LD) begin
                            terms.e_ram = 1'b1;
                            terms.s_reg = reg_sel(rb);
                        end else if (step[4]) begin
                            terms.e_reg = reg_sel(rb);
                            terms.s_ram = 1'b1;
                        end
                    end
                    OP_DATA: begin
                        if (step[3]) begin
                            incr = 1'b1;
                        end else if (step[4]) begin
                            terms.e_ram = 1'b1;
                            terms.s_reg = reg_sel(rb);
                        end else if (step[5]) begin
                            terms.e_acc = 1'b1;
                            terms.s_iar = 1'b1;
                        end
                    end
                    OP_JMPR: begin
                        if (step[3]) begin
                            terms.e_reg = reg_sel(rb);
                            terms.s_iar = 1'b1;
                        end
                    end
                    OP_JMP: begin
                        if (step[3]) begin
                            terms.e_iar = 1'b1;
                            terms.s_mar = 1'b1;
                        end else if (step[4]) begin
                            terms.e_ram = 1'b1;
                            terms.s_iar = 1'b1;
                        end
                    end
                    OP_JCOND: begin
                        // Step 6 takes the jump target from RAM only when a tested flag is set.
                        if (step[3]) begin
                            incr = 1'b1;
                        end else if (step[4]) begin
                            terms.e_acc = 1'b1;
                            terms.s_iar = 1'b1;
                        end else if (step[5] && (ir[3:0] & flags) != 4'b0000) begin
                            terms.e_ram = 1'b1;
                            terms.s_iar = 1'b1;
                        end
                    end
                    OP_CLF: begin
                        if (step[3]) begin
                            terms.bus1      = 1'b1;
                            terms.s_flags   = 1'b1;
                            terms.flags_clr = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        // IAR + 1 into ACC and IAR into MAR: shared by fetch, DATA and JCOND.
        if (incr) begin
            terms.bus1   = 1'b1;
            terms.e_iar  = 1'b1;
            terms.s_mar  = 1'b1;
            terms.s_acc  = 1'b1;
            terms.alu_op = ALU_ADD;
        end
    end

endmodule

// File: rtl/step_control.sv
// Control section: gates decoded terms with the clke/clks phases and holds IR, flags,
// the retired-instruction counter and the sticky step-fault flag.
module step_control
    import step_control_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           reset,
    step_control_if.slave  ctl
);

    strobes_t         t;
    logic [WIDTH-1:0] ir_q;
    logic [3:0]       flags_q;
    logic [3:0]       alu_flags;
    logic [CNT_W-1:0] icount_q;
    logic             err_q;
    logic [5:0]       step_q;
    logic             e_gate;
    logic             s_gate;

    step_decode u_decode (
        .step  (ctl.step),
        .ir    (ir_q[7:0]),
        .flags (flags_q),
        .terms (t)
    );

    always_comb begin
        alu_flags         = 4'b0000;
        alu_flags[FLAG_C] = ctl.alu_c;
        alu_flags[FLAG_A] = ctl.alu_a;
        alu_flags[FLAG_E] = ctl.alu_e;
        alu_flags[FLAG_Z] = ctl.alu_z;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_q     <= '0;
            flags_q  <= '0;
            icount_q <= '0;
            err_q    <= 1'b0;
            step_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            step_q <= ctl.step;
            if (ctl.clks && t.s_ir) begin
                ir_q <= ctl.bus;
            end
            if (ctl.clks && t.s_flags) begin
                flags_q <= t.flags_clr ? 4'b0000 : alu_flags;
            end
            // A step-6 to step-1 transition retires one instruction, however long each step dwells.
            if (step_q[5] && ctl.step[0]) begin
                icount_q <= icount_q + CNT_W'(1);
            end
            if (multi_hot(ctl.step)) begin
                err_q <= 1'b1;
            end
        end
    end

    // NOTE: reset also masks the combinational strobes, so asserting it mid-step silences them at once.
    assign e_gate = reset & ctl.clke;
    assign s_gate = reset & ctl.clks;

    assign ctl.bus1    = e_gate & t.bus1;
    assign ctl.e_ram   = e_gate & t.e_ram;
    assign ctl.e_acc   = e_gate & t.e_acc;
    assign ctl.e_iar   = e_gate & t.e_iar;
    assign ctl.e_reg   = {4{e_gate}} & t.e_reg;

    assign ctl.s_mar   = s_gate & t.s_mar;
    assign ctl.s_ir    = s_gate & t.s_ir;
    assign ctl.s_iar   = s_gate & t.s_iar;
    assign ctl.s_acc   = s_gate & t.s_acc;
    assign ctl.s_ram   = s_gate & t.s_ram;
    assign ctl.s_tmp   = s_gate & t.s_tmp;
    assign ctl.s_flags = s_gate & t.s_flags;
    assign ctl.s_reg   = {4{s_gate}} & t.s_reg;

    assign ctl.alu_op  = reset ? t.alu_op : ALU_ADD;
    assign ctl.alu_cin = reset & t.alu_cin;

    assign ctl.ir      = ir_q;
    assign ctl.flags   = flags_q;
    assign ctl.icount  = icount_q;
    assign ctl.err     = err_q;

endmodule

// File: tb/tb_step_control.sv
// Scoreboarded bench for step_control: the stimulus pushes model predictions per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_step_control;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    step_control_if #(.WIDTH(8), .CNT_W(16)) ctl ();

    step_control #(.WIDTH(8), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (ctl.slave)
    );

    typedef struct packed {
        logic       bus1, e_ram, e_acc, e_iar;
        logic [3:0] e_reg;
        logic       s_mar, s_ir, s_iar, s_acc, s_ram, s_tmp, s_flags;
        logic [3:0] s_reg;
        logic [2:0] alu_op;
        logic       alu_cin;
    } obs_t;

    typedef struct packed {
        obs_t        o;
        logic [7:0]  ir;
        logic [3:0]  flags;
        logic [15:0] icount;
        logic        err;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference model state and the inputs currently applied to the DUT.
    bit         m_rst   = 1'b0;
    logic [5:0] m_step  = '0;
    bit         m_ce    = 1'b0;
    bit         m_cs    = 1'b0;
    logic [7:0] m_bus   = '0;
    logic [3:0] m_alu   = '0;
    logic [7:0] m_ir    = '0;
    logic [3:0] m_flags = '0;
    int         m_icount = 0;
    bit         m_err   = 1'b0;
    logic [5:0] m_prev  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level description of what each step of each instruction does.
    function automatic obs_t expect_out(input bit rst, input logic [5:0] st, input bit ce,
                                        input bit cs, input logic [7:0] ir, input logic [3:0] fl);
        obs_t o;
        int n, ra, rb, reg_en, reg_set;
        bit b1, er, ea, ei, sm, sir, siar, sacc, sram, stmp, sfl, cin;
        logic [2:0] op;
        o = '0; n = 0; reg_en = -1; reg_set = -1; op = 3'd0; cin = 1'b0;
        {b1, er, ea, ei, sm, sir, siar, sacc, sram, stmp, sfl} = '0;
        if (!rst || $countones(st) != 1) return o;
        for (int i = 0; i < 6; i++) if (st[i]) n = i + 1;
        ra = int'(ir[3:2]);
        rb = int'(ir[1:0]);
        if (n == 1) begin
            {b1, ei, sm, sacc} = 4'hF;
        end else if (n == 2) begin
            er = 1; sir = 1;
        end else if (n == 3) begin
            ea = 1; siar = 1;
        end else if (ir[7]) begin
            if (n == 4) begin reg_en = rb; stmp = 1; end
            if (n == 5) begin reg_en = ra; sacc = 1; sfl = 1; op = ir[6:4]; cin = fl[3]; end
            if (n == 6 && ir[6:4] != 3'd7) begin ea = 1; reg_set = rb; end
        end else begin
            case (ir[6:4])
                3'd0: if (n == 4) begin reg_en = ra; sm = 1; end
                      else if (n == 5) begin er = 1; reg_set = rb; end
                3'd1: if (n == 4) begin reg_en = ra; sm = 1; end
                      else if (n == 5) begin reg_en = rb; sram = 1; end
                3'd2: if (n == 4) {b1, ei, sm, sacc} = 4'hF;
                      else if (n == 5) begin er = 1; reg_set = rb; end
                      else begin ea = 1; siar = 1; end
                3'd3: if (n == 4) begin reg_en = rb; siar = 1; end
                3'd4: if (n == 4) begin ei = 1; sm = 1; end
                      else if (n == 5) begin er = 1; siar = 1; end
                3'd5: if (n == 4) {b1, ei, sm, sacc} = 4'hF;
                      else if (n == 5) begin ea = 1; siar = 1; end
                      else if ((ir[3:0] & fl) != 0) begin er = 1; siar = 1; end
                3'd6: if (n == 4) begin b1 = 1; sfl = 1; end
                default: ;
            endcase
        end
        o.bus1 = b1 & ce; o.e_ram = er & ce; o.e_acc = ea & ce; o.e_iar = ei & ce;
        o.e_reg = (reg_en >= 0 && ce) ? 4'(1 << reg_en) : 4'd0;
        o.s_mar = sm & cs; o.s_ir = sir & cs; o.s_iar = siar & cs; o.s_acc = sacc & cs;
        o.s_ram = sram & cs; o.s_tmp = stmp & cs; o.s_flags = sfl & cs;
        o.s_reg = (reg_set >= 0 && cs) ? 4'(1 << reg_set) : 4'd0;
        o.alu_op = op; o.alu_cin = cin;
        return o;
    endfunction

    task automatic model_clear();
        m_ir = '0; m_flags = '0; m_icount = 0; m_err = 1'b0; m_prev = '0;
    endtask

    // Register updates at a rising edge, using the inputs held during the cycle before it.
    task automatic model_tick();
        obs_t u;
        if (!m_rst) return;
        u = expect_out(1'b1, m_step, 1'b1, 1'b1, m_ir, m_flags);
        if (u.s_flags && m_cs) m_flags = (m_step == 6'b001000) ? 4'b0000 : m_alu;
        if (u.s_ir && m_cs) m_ir = m_bus;
        if (m_prev[5] && m_step[0]) m_icount = (m_icount + 1) % 65536;
        if ($countones(m_step) > 1) m_err = 1'b1;
        m_prev = m_step;
    endtask

    task automatic drive(input bit rst, input bit mid_rst, input logic [5:0] st, input bit ce,
                         input bit cs, input logic [7:0] b, input logic [3:0] alu);
        exp_t e;
        @(posedge clk);
        model_tick();
        #1;
        m_rst = rst; m_step = st; m_ce = ce; m_cs = cs; m_bus = b; m_alu = alu;
        reset = rst; ctl.step = st; ctl.clke = ce; ctl.clks = cs; ctl.bus = b;
        {ctl.alu_c, ctl.alu_a, ctl.alu_e, ctl.alu_z} = alu;
        if (!rst) model_clear();
        if (mid_rst) begin
            #1;
            m_rst = 1'b0; reset = 1'b0;
            model_clear();
        end
        e.o      = expect_out(m_rst, m_step, m_ce, m_cs, m_ir, m_flags);
        e.ir     = m_ir;
        e.flags  = m_flags;
        e.icount = 16'(m_icount);
        e.err    = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 8'($urandom), 4'($urandom));
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [7:0] op, input logic [3:0] alu, input bit rnd,
                             input int reset_at);
        for (int s = 1; s <= 6; s++) begin
            logic [5:0] st;
            int dwell;
            st = 6'(1 << (s - 1));
            dwell = rnd ? int'($urandom_range(1, 3)) : 2;
            for (int c = 0; c < dwell; c++) begin
                bit last, ce, cs;
                logic [7:0] b;
                last = (c == dwell - 1);
                b = (s == 2) ? op : 8'($urandom);
                ce = (last || !rnd) ? 1'b1 : 1'($urandom_range(0, 1));
                cs = last ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
                if (s == reset_at && last) begin
                    drive(1'b1, 1'b1, st, ce, cs, b, alu);
                    return;
                end
                drive(1'b1, 1'b0, st, ce, cs, b, alu);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                obs_t a;
                e = exp_q.pop_front();
                a = {ctl.bus1, ctl.e_ram, ctl.e_acc, ctl.e_iar, ctl.e_reg,
                     ctl.s_mar, ctl.s_ir, ctl.s_iar, ctl.s_acc, ctl.s_ram, ctl.s_tmp,
                     ctl.s_flags, ctl.s_reg, ctl.alu_op, ctl.alu_cin};
                check("strobes", 32'(a), 32'(e.o));
                check("ir", 32'(ctl.ir), 32'(e.ir));
                check("flags", 32'(ctl.flags), 32'(e.flags));
                check("icount", 32'(ctl.icount), 32'(e.icount));
                check("err", 32'(ctl.err), 32'(e.err));
            end
        end
    end

    initial begin
        ctl.clke = 1'b0; ctl.clks = 1'b0; ctl.step = '0; ctl.bus = '0;
        {ctl.alu_c, ctl.alu_a, ctl.alu_e, ctl.alu_z} = 4'b0000;

        // Reset state with both phases active and a live step.
        drive(1'b0, 1'b0, 6'b000001, 1'b1, 1'b1, 8'hFF, 4'hF);
        drive(1'b0, 1'b0, 6'b000001, 1'b1, 1'b1, 8'hFF, 4'hF);
        settle();
        check("rst_bus1", 32'(ctl.bus1), 0);
        check("rst_alu_op", 32'(ctl.alu_op), 0);
        check("rst_ir", 32'(ctl.ir), 0);
        check("rst_err", 32'(ctl.err), 0);
        drive(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 8'h00, 4'h0);

        // ADD R0,R1 with carry out set, then conditional jumps, CLF and CMP.
        run_instr(8'h81, 4'b1000, 1'b0, 0);
        idle(); settle();
        check("add_ir", 32'(ctl.ir), 32'h81);
        check("add_flags", 32'(ctl.flags), 32'b1000);
        run_instr(8'h58, 4'b0000, 1'b0, 0);
        run_instr(8'h60, 4'b1111, 1'b0, 0);
        idle(); settle();
        check("clf_flags", 32'(ctl.flags), 0);
        run_instr(8'h58, 4'b1111, 1'b0, 0);
        run_instr(8'hF1, 4'b0110, 1'b0, 0);
        run_instr(8'h60, 4'b1111, 1'b0, 0);
        idle(); settle();
        check("cmp_clf_flags", 32'(ctl.flags), 0);

        // Counting: three NOP instructions followed by the next step 1.
        drive(1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        drive(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        for (int k = 0; k < 3; k++) run_instr(8'h70, 4'hF, 1'b0, 0);
        drive(1'b1, 1'b0, 6'b000001, 1'b1, 1'b0, 8'h00, 4'h0);
        drive(1'b1, 1'b0, 6'b000001, 1'b1, 1'b0, 8'h00, 4'h0);
        idle(); settle();
        check("icount_3", 32'(ctl.icount), 3);

        // Step fault: strobes silent at once, err sticky from the next edge.
        drive(1'b1, 1'b0, 6'b000011, 1'b1, 1'b1, 8'h81, 4'hF);
        settle();
        check("fault_bus1", 32'(ctl.bus1), 0);
        check("fault_s_mar", 32'(ctl.s_mar), 0);
        idle(); settle();
        check("fault_err", 32'(ctl.err), 1);
        run_instr(8'h81, 4'h0, 1'b0, 0);
        idle(); settle();
        check("err_held", 32'(ctl.err), 1);

        // Asynchronous reset during step 5 of an ALU instruction.
        run_instr(8'h81, 4'hF, 1'b0, 5);
        settle();
        check("mid_rst_e_reg", 32'(ctl.e_reg), 0);
        check("mid_rst_icount", 32'(ctl.icount), 0);
        check("mid_rst_err", 32'(ctl.err), 0);
        drive(1'b0, 1'b0, 6'b010000, 1'b1, 1'b1, 8'h00, 4'hF);
        drive(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        run_instr(8'h93, 4'b0101, 1'b0, 0);
        idle(); settle();
        check("post_rst_ir", 32'(ctl.ir), 32'h93);

        // Randomized instruction stream with irregular phases, dwell, idles, faults and resets.
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 9) == 0) idle();
            if ($urandom_range(0, 149) == 0)
                drive(1'b1, 1'b0, 6'($urandom), 1'b1, 1'b1, 8'($urandom), 4'($urandom));
            if ($urandom_range(0, 59) == 0) begin
                drive(1'b0, 1'b0, 6'b0, 1'b0, 1'b0, 8'h00, 4'h0);
                drive(1'b1, 1'b0, 6'b0, 1'b0, 1'b0, 8'h00, 4'h0);
            end
            run_instr(8'($urandom), 4'($urandom), 1'b1, 0);
        end
        idle();
        settle();
        check("scoreboard_drain", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
